uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 26 ++
 rtl/uart_rx_frame_ctrl_frame_buffer.sv | 33 +++
 rtl/uart_rx_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the framed UART receive controller:
// frame FSM states, default sync marker and error-vector bit positions.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    FrIdle,
    FrLength,
    FrPayload,
    FrChecksum,
    FrDeliver
  } RxFrameState;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int ERR_W       = 4;
  localparam int ERR_LEN     = 0;
  localparam int ERR_CSUM    = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_OVERRUN = 3;

  // Address width for a buffer of the given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_frame_buffer.sv
// Payload store for one frame: synchronous write, registered single-cycle read.
// Contents survive reset; only the read register is cleared.
module uart_rx_frame_ctrl_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Framed UART receive controller: SYNC, LEN, payload[, checksum] -> byte stream.
// Define RX_FRAME_CHECKSUM_EN to require a trailing checksum byte per frame.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic       sourceClk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_complete,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       busy,
  output logic       err_len,
  output logic       err_csum,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int             AW        = addr_width(MAX_LEN);
  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  RxFrameState      state;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [7:0]       rd_idx;
  logic [TW-1:0]    tmo;
  logic [ERR_W-1:0] err_reg;
  logic             armed;

  logic             active;
  logic             tmo_expired;
  logic             last_rd;
  logic             rd_adv;
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]       sum;
  logic [7:0]       sum_next;
  assign sum_next = sum + rx_byte;
`endif

  // A byte arriving on the expiry cycle wins over the timeout.
  assign active      = (state == FrLength) || (state == FrPayload) || (state == FrChecksum);
  assign tmo_expired = active && !rx_complete && (tmo == TMO_LAST);

  // Read address looks one byte ahead on a handshake so the next byte is
  // ready the following cycle; it holds while stalled.
  assign last_rd = (rd_idx == len - 8'd1);
  assign rd_adv  = (state == FrDeliver) && out_valid && out_ready && !last_rd;
  assign rd_addr = rd_adv ? AW'(rd_idx + 8'd1) : AW'(rd_idx);
  assign rd_en   = (state == FrDeliver);
  assign wr_en   = (state == FrPayload) && rx_complete;
  assign wr_addr = AW'(idx);

  uart_rx_frame_ctrl_frame_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buffer (
    .clk     (sourceClk),
    .srst    (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rx_byte),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  always_ff @(posedge sourceClk) begin
    if (reset) begin
      state     <= FrIdle;
      len       <= '0;
      idx       <= '0;
      rd_idx    <= '0;
      frame_len <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_reg   <= '0;
      tmo       <= '0;
      armed     <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      armed   <= 1'b1;
      err_reg <= '0;
      tmo     <= (active && !rx_complete) ? tmo + 1'b1 : '0;
      case (state)
        FrIdle: begin
          if (rx_complete && armed && (rx_byte == SYNC_BYTE)) begin
            state <= FrLength;
          end
        end
        FrLength: begin
          if (rx_complete) begin
            if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
              err_reg[ERR_LEN] <= 1'b1;
              state            <= FrIdle;
            end else begin
              len   <= rx_byte;
              idx   <= '0;
              state <= FrPayload;
`ifdef RX_FRAME_CHECKSUM_EN
              sum   <= rx_byte;
`endif
            end
          end
        end
        FrPayload: begin
          if (rx_complete) begin
            idx <= idx + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
            sum <= sum_next;
`endif
            if (idx == len - 8'd1) begin
`ifdef RX_FRAME_CHECKSUM_EN
              state     <= FrChecksum;
`else
              state     <= FrDeliver;
              rd_idx    <= '0;
              frame_len <= len;
`endif
            end
          end
        end
`ifdef RX_FRAME_CHECKSUM_EN
        FrChecksum: begin
          if (rx_complete) begin
            if (sum_next == 8'd0) begin
              state     <= FrDeliver;
              rd_idx    <= '0;
              frame_len <= len;
            end else begin
              err_reg[ERR_CSUM] <= 1'b1;
              state             <= FrIdle;
            end
          end
        end
`endif
        FrDeliver: begin
          if (rx_complete) begin
            err_reg[ERR_OVERRUN] <= 1'b1;
          end
          // First cycle in FrDeliver primes the buffer read; valid follows.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_last  <= (len == 8'd1);
          end else if (out_ready) begin
            if (last_rd) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= FrIdle;
            end else begin
              rd_idx   <= rd_idx + 8'd1;
              out_last <= (rd_idx + 8'd2 == len);
            end
          end
        end
        default: state <= FrIdle;
      endcase
      if (tmo_expired) begin
        err_reg[ERR_TIMEOUT] <= 1'b1;
        state                <= FrIdle;
      end
    end
  end

  assign busy        = (state != FrIdle);
  assign err_len     = err_reg[ERR_LEN];
  assign err_csum    = err_reg[ERR_CSUM];
  assign err_timeout = err_reg[ERR_TIMEOUT];
  assign err_overrun = err_reg[ERR_OVERRUN];

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; frames carry a checksum byte
// only when RX_FRAME_CHECKSUM_EN is defined.
module tb_uart_rx_frame_ctrl;

  localparam int TMO = 20;

  logic       sourceClk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_complete = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] frame_len;
  logic       busy;
  logic       err_len, err_csum, err_timeout, err_overrun;

  int checks = 0;
  int failures = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int n_valid = 0;

  uart_rx_frame_ctrl #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .sourceClk   (sourceClk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_complete (rx_complete),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_len   (frame_len),
    .busy        (busy),
    .err_len     (err_len),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 sourceClk = ~sourceClk;

  always @(negedge sourceClk) begin
    if (err_timeout) n_tmo++;
    if (err_overrun) n_ovr++;
    if (out_valid) n_valid++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sourceClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    rx_byte = 8'h00;
    $display("tb: rx byte %02h busy=%0b", b, busy);
  endtask

  task automatic send_frame(input logic [7:0] p[$]);
    logic [7:0] s;
    s = 8'(p.size());
    send_byte(8'hA5);
    send_byte(s);
    foreach (p[i]) begin
      send_byte(p[i]);
      s = s + p[i];
    end
`ifdef RX_FRAME_CHECKSUM_EN
    send_byte(8'd0 - s);
`endif
  endtask

  task automatic drain(input string tag, input logic [7:0] p[$]);
    check({tag, "_gap"}, 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    foreach (p[i]) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(p[i]));
      check({tag, "_last"}, 32'(out_last), (i == p.size() - 1) ? 32'd1 : 32'd0);
      $display("tb: %s out byte %0d data=%02h last=%0b", tag, i, out_data, out_last);
      tick();
    end
    check({tag, "_done"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_len"}, 32'(frame_len), 32'(p.size()));
  endtask

  initial begin
    logic [7:0] fr[$];
    int snap;

    // Reset state
    tick();
    tick();
    check("rst_outs", {out_valid, out_last, busy, err_len, err_csum, err_timeout, err_overrun}, 32'd0);
    check("rst_data", {out_data, frame_len}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame 11,22,33 (checksum 97)
    fr = {8'h11, 8'h22, 8'h33};
    send_frame(fr);
    check("f1_busy", 32'(busy), 32'd1);
    drain("f1", fr);
    check("f1_errs", {err_len, err_csum, err_timeout, err_overrun}, 32'd0);
    tick();
    check("f1_len_hold", 32'(frame_len), 32'd3);

`ifdef RX_FRAME_CHECKSUM_EN
    // Bad checksum
    snap = n_valid;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    check("csum_pulse", 32'(err_csum), 32'd1);
    check("csum_busy", 32'(busy), 32'd0);
    tick();
    check("csum_once", 32'(err_csum), 32'd0);
    check("csum_noval", n_valid - snap, 32'd0);
`endif

    // Length errors
    send_byte(8'hA5); send_byte(8'h00);
    check("len0_pulse", 32'(err_len), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_once", 32'(err_len), 32'd0);
    send_byte(8'hA5); send_byte(8'h11);
    check("len17_pulse", 32'(err_len), 32'd1);
    check("len17_busy", 32'(busy), 32'd0);

    // Timeout after one payload byte
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    snap = n_tmo;
    repeat (TMO - 1) tick();
    check("tmo_early_busy", 32'(busy), 32'd1);
    check("tmo_early_err", 32'(err_timeout), 32'd0);
    tick();
    check("tmo_pulse", 32'(err_timeout), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("tmo_count", n_tmo - snap, 32'd1);
    fr = {8'h11, 8'h22, 8'h33};
    send_frame(fr);
    drain("f2", fr);

    // Byte on the expiry cycle is honoured
    snap = n_tmo;
    send_byte(8'hA5); send_byte(8'h02);
    repeat (TMO - 1) tick();
    send_byte(8'h10);
    check("edge_busy", 32'(busy), 32'd1);
    send_byte(8'h20);
`ifdef RX_FRAME_CHECKSUM_EN
    send_byte(8'hCE);
`endif
    fr = {8'h10, 8'h20};
    drain("edge", fr);
    check("edge_no_tmo", n_tmo - snap, 32'd0);

    // Stall pattern 1,0,0,1 with an overrun byte while stalled
    snap = n_ovr;
    fr = {8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr);
    out_ready = 1'b1;
    tick();
    check("stall_d0", 32'(out_data), 32'h01);
    tick();
    check("stall_d1", 32'(out_data), 32'h02);
    out_ready = 1'b0;
    tick();
    check("stall_hold1", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'h02});
    rx_byte = 8'hA5;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    check("stall_hold2", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'h02});
    check("ovr_pulse", 32'(err_overrun), 32'd1);
    out_ready = 1'b1;
    tick();
    check("stall_d2", 32'(out_data), 32'h03);
    tick();
    check("stall_d3", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b1, 8'h04});
    tick();
    check("stall_done", 32'(out_valid), 32'd0);
    check("ovr_count", n_ovr - snap, 32'd1);

    // Reset during payload, then first post-reset strobe ignored
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    check("rp_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("rp_outs", {out_valid, out_last, busy, err_len, err_csum, err_timeout, err_overrun}, 32'd0);
    check("rp_data", {out_data, frame_len}, 32'd0);
    reset = 1'b0;
    rx_byte = 8'hA5;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    check("rp_ignore", 32'(busy), 32'd0);

    // Reset during delivery
    fr = {8'hAA, 8'hBB};
    send_frame(fr);
    out_ready = 1'b0;
    tick();
    tick();
    check("rd_stalled", {out_valid, out_data}, {23'd0, 1'b1, 8'hAA});
    reset = 1'b1;
    tick();
    check("rd_outs", {out_valid, out_last, busy, err_len, err_csum, err_timeout, err_overrun}, 32'd0);
    check("rd_data", {out_data, frame_len}, 32'd0);
    reset = 1'b0;
    tick();

    fr = {8'h7F};
    send_frame(fr);
    drain("post", fr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
